// File: rtl/lpc_pkg.sv
// Shared constants for the LPC cycle decoder: FSM encodings, protocol
// nibble codes and the address filter helper.
package lpc_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_CYCTYPE = 3'd2;
   localparam logic [2:0] ST_ADDR    = 3'd3;
   localparam logic [2:0] ST_WDATA   = 3'd4;
   localparam logic [2:0] ST_TAR1    = 3'd5;
   localparam logic [2:0] ST_SYNC    = 3'd6;
   localparam logic [2:0] ST_RDATA   = 3'd7;

   localparam logic [3:0] START_CODE = 4'b0000;

   localparam logic [1:0] CT_IO  = 2'b00;
   localparam logic [1:0] CT_MEM = 2'b01;

   localparam logic [3:0] SYNC_READY      = 4'b0000;
   localparam logic [3:0] SYNC_READY_MORE = 4'b1001;
   localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
   localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR      = 4'b1010;

   localparam logic [3:0] ADDR_NIBBLES_IO  = 4'd4;
   localparam logic [3:0] ADDR_NIBBLES_MEM = 4'd8;

   function automatic logic addr_match(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// Counts consecutive non-terminal SYNC nibbles; timeout flags the
// increment that would reach the limit.
module lpc_sync_timer
   import lpc_pkg::*;
#(
   parameter int unsigned SYNC_TIMEOUT = 16
) (
   input  logic lpc_clock,
   input  logic lpc_reset,
   input  logic clear,
   input  logic inc,
   output logic timeout
);

   localparam int unsigned CNT_W = $clog2(SYNC_TIMEOUT + 1);

   logic [CNT_W-1:0] count_r;

   assign timeout = inc && (count_r == CNT_W'(SYNC_TIMEOUT - 1));

   // Wait counter: cleared outside SYNC, stepped on each wait nibble
   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         count_r <= CNT_W'(0);
      end else if (clear) begin
         count_r <= CNT_W'(0);
      end else if (inc && !timeout) begin
         count_r <= count_r + CNT_W'(1);
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC decoder: follows I/O and memory read/write cycles on the bus
// and emits one registered record per completed transaction.
module lpc_cycle_decoder
   import lpc_pkg::*;
#(
   parameter bit          MEM_ENABLE   = 1'b1,
   parameter int unsigned SYNC_TIMEOUT = 16,
   parameter bit          FILTER_EN    = 1'b0,
   parameter logic [31:0] FILTER_BASE  = 32'h0000_0080,
   parameter logic [31:0] FILTER_MASK  = 32'hFFFF_FFFF
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic        out_mode,
   output logic        out_direction,
   output logic [31:0] out_addr,
   output logic [7:0]  out_data,
   output logic        out_error,
   output logic        out_latch,
   output logic        out_abort
);

   logic [2:0]  state_r;
   logic [2:0]  state_nxt_s;
   logic [3:0]  nib_cnt_r;
   logic        cyc_io_r;
   logic        cyc_wr_r;
   logic [31:0] addr_r;
   logic [7:0]  data_r;
   logic        frame_abort_s;
   logic        report_s;
   logic [7:0]  rep_data_s;
   logic        rep_err_s;
   logic        abort_s;
   logic        inc_s;
   logic        clear_s;
   logic        timeout_s;
   logic        pass_s;
   logic [3:0]  last_nib_s;

   assign frame_abort_s = (state_r != ST_IDLE) && (state_r != ST_START) && !lpc_frame;
   assign last_nib_s    = (cyc_io_r ? ADDR_NIBBLES_IO : ADDR_NIBBLES_MEM) - 4'd1;
   assign clear_s       = (state_r != ST_SYNC);
   assign pass_s        = !FILTER_EN || addr_match(addr_r, FILTER_BASE, FILTER_MASK);

   lpc_sync_timer #(
      .SYNC_TIMEOUT (SYNC_TIMEOUT)
   ) u_sync_timer (
      .lpc_clock (lpc_clock),
      .lpc_reset (lpc_reset),
      .clear     (clear_s),
      .inc       (inc_s),
      .timeout   (timeout_s)
   );

   // Next state and report/abort decisions; LFRAME# low overrides every phase
   always_comb begin
      state_nxt_s = state_r;
      report_s    = 1'b0;
      rep_data_s  = data_r;
      rep_err_s   = 1'b0;
      abort_s     = 1'b0;
      inc_s       = 1'b0;
      if (frame_abort_s) begin
         abort_s     = 1'b1;
         state_nxt_s = (lpc_ad == START_CODE) ? ST_START : ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!lpc_frame && (lpc_ad == START_CODE)) state_nxt_s = ST_START;
               else                                      state_nxt_s = ST_IDLE;
            end
            ST_START: begin
               if (!lpc_frame) begin
                  state_nxt_s = (lpc_ad == START_CODE) ? ST_START : ST_IDLE;
               end else if ((lpc_ad[3:2] == CT_IO) || ((lpc_ad[3:2] == CT_MEM) && MEM_ENABLE)) begin
                  state_nxt_s = ST_ADDR;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_ADDR: begin
               if (nib_cnt_r == last_nib_s) state_nxt_s = cyc_wr_r ? ST_WDATA : ST_TAR1;
               else                         state_nxt_s = ST_ADDR;
            end
            ST_WDATA: begin
               if (nib_cnt_r == 4'd1) state_nxt_s = ST_TAR1;
               else                   state_nxt_s = ST_WDATA;
            end
            ST_TAR1: begin
               if (nib_cnt_r == 4'd1) state_nxt_s = ST_SYNC;
               else                   state_nxt_s = ST_TAR1;
            end
            ST_SYNC: begin
               if ((lpc_ad == SYNC_READY) || (lpc_ad == SYNC_READY_MORE)) begin
                  if (cyc_wr_r) begin
                     report_s    = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_RDATA;
                  end
               end else if (lpc_ad == SYNC_ERROR) begin
                  report_s    = 1'b1;
                  rep_err_s   = 1'b1;
                  rep_data_s  = cyc_wr_r ? data_r : 8'h00;
                  state_nxt_s = ST_IDLE;
               end else begin
                  inc_s = 1'b1;
                  if (timeout_s) begin
                     abort_s     = 1'b1;
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_SYNC;
                  end
               end
            end
            ST_RDATA: begin
               if (nib_cnt_r == 4'd1) begin
                  report_s    = 1'b1;
                  rep_data_s  = {lpc_ad, data_r[3:0]};
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_RDATA;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State, phase nibble counter (restarts on every transition) and cycle capture
   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         state_r   <= ST_IDLE;
         nib_cnt_r <= 4'd0;
         cyc_io_r  <= 1'b0;
         cyc_wr_r  <= 1'b0;
         addr_r    <= 32'h0;
         data_r    <= 8'h00;
      end else begin
         state_r   <= state_nxt_s;
         nib_cnt_r <= (state_nxt_s != state_r) ? 4'd0 : nib_cnt_r + 4'd1;
         if (!frame_abort_s) begin
            case (state_r)
               ST_START: begin
                  if (lpc_frame) begin
                     cyc_io_r <= (lpc_ad[3:2] == CT_IO);
                     cyc_wr_r <= lpc_ad[1];
                     addr_r   <= 32'h0;
                  end
               end
               ST_ADDR: addr_r <= {addr_r[27:0], lpc_ad};
               ST_WDATA, ST_RDATA: begin
                  if (nib_cnt_r == 4'd0) data_r[3:0] <= lpc_ad;
                  else                   data_r[7:4] <= lpc_ad;
               end
               default: ;
            endcase
         end
      end
   end

   // Registered record and strobes; fields only move on a reported cycle
   always_ff @(posedge lpc_clock or posedge lpc_reset) begin
      if (lpc_reset) begin
         out_mode      <= 1'b0;
         out_direction <= 1'b0;
         out_addr      <= 32'h0;
         out_data      <= 8'h00;
         out_error     <= 1'b0;
         out_latch     <= 1'b0;
         out_abort     <= 1'b0;
      end else begin
         out_latch <= report_s && pass_s;
         out_abort <= abort_s;
         if (report_s && pass_s) begin
            out_mode      <= cyc_io_r;
            out_direction <= cyc_wr_r;
            out_addr      <= addr_r;
            out_data      <= rep_data_s;
            out_error     <= rep_err_s;
         end
      end
   end

endmodule
